// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier with a go/busy/done handshake.
// One add cycle plus one shift cycle per multiplier bit; the latency is fixed
// and does not depend on the operand values.
module shift_add_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StShift,
    StDone
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;        // accumulator including carry
  logic [WIDTH-1:0]   q_q, q_d;        // multiplier, consumed LSB-first
  logic [WIDTH-1:0]   m_q, m_d;        // latched multiplicand
  logic [CntW-1:0]    count_q, count_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  // Controller and datapath next-state logic.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    count_d   = count_q;
    product_d = product_q;
    unique case (state_q)
      StIdle: begin
        if (go) begin
          a_d     = '0;
          q_d     = multiplier;
          m_d     = multiplicand;
          count_d = CntW'(WIDTH);
          state_d = StAdd;
        end
      end
      StAdd: begin
        // WIDTH+1-bit sum: the carry lands in a_q[WIDTH], never overflows.
        if (q_q[0]) begin
          a_d = a_q + {1'b0, m_q};
        end
        state_d = StShift;
      end
      StShift: begin
        // {A,Q} shifted right by one; A[0] drops into the top of Q.
        a_d     = {1'b0, a_q[WIDTH:1]};
        q_d     = {a_q[0], q_q[WIDTH-1:1]};
        count_d = count_q - CntW'(1);
        if (count_q == CntW'(1)) begin
          // Post-shift {A[WIDTH-1:0],Q} expressed on the pre-shift registers.
          product_d = {a_q, q_q[WIDTH-1:1]};
          state_d   = StDone;
        end else begin
          state_d = StAdd;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Handshake outputs decoded straight from the state register.
  always_comb begin
    busy    = (state_q != StIdle);
    done    = (state_q == StDone);
    product = product_q;
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier (WIDTH = 4).
module tb_shift_add_multiplier;

  logic       clk;
  logic       reset;
  logic       go;
  logic [3:0] multiplicand;
  logic [3:0] multiplier;
  logic       busy;
  logic       done;
  logic [7:0] product;

  int n_checks;
  int n_fail;

  shift_add_multiplier #(
    .WIDTH(4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .go          (go),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .busy        (busy),
    .done        (done),
    .product     (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before driving or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Wait for done after an accept edge; returns edges counted since accept.
  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Full operation from IDLE: accept, latency, result, single-cycle done.
  task automatic do_op(input logic [3:0] m, input logic [3:0] q, input int exp,
                       input string tag);
    int lat;
    go           = 1'b1;
    multiplicand = m;
    multiplier   = q;
    tick();
    go           = 1'b0;
    multiplicand = 4'($urandom);
    multiplier   = 4'($urandom);
    check({tag, " busy_after_go"}, 32'(busy), 32'd1);
    wait_done(lat);
    check({tag, " latency"}, 32'(lat), 32'd8);
    check({tag, " product"}, 32'(product), 32'(exp));
    tick();
    check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    check({tag, " busy_fall"}, 32'(busy), 32'd0);
    check({tag, " product_hold"}, 32'(product), 32'(exp));
  endtask

  initial begin
    int lat;
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b1;
    go           = 1'b0;
    multiplicand = 4'd0;
    multiplier   = 4'd0;
    tick();
    tick();
    reset = 1'b0;

    // Reset state and idle hold.
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst product", 32'(product), 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle busy", 32'(busy), 32'd0);
      check("idle done", 32'(done), 32'd0);
      check("idle product", 32'(product), 32'd0);
    end

    // Max operands, then typical and zero operands.
    do_op(4'd15, 4'd15, 225, "15x15");
    do_op(4'd13, 4'd11, 143, "13x11");
    do_op(4'd0, 4'd13, 0, "0x13");

    // go re-asserted mid-operation and during done must be ignored.
    go           = 1'b1;
    multiplicand = 4'd7;
    multiplier   = 4'd6;
    tick();
    multiplicand = 4'd1;
    multiplier   = 4'd1;
    check("ign busy", 32'(busy), 32'd1);
    wait_done(lat);
    check("ign latency", 32'(lat), 32'd8);
    check("ign product", 32'(product), 32'd42);
    check("ign go_in_done", 32'(go), 32'd1);
    go = 1'b0;
    tick();
    check("ign done_one_cycle", 32'(done), 32'd0);
    check("ign busy_fall", 32'(busy), 32'd0);
    do_op(4'd2, 4'd3, 6, "after_ign");

    // Reset aborts an operation in flight; no partial result, no done.
    go           = 1'b1;
    multiplicand = 4'd9;
    multiplier   = 4'd9;
    tick();
    go = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort product", 32'(product), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("abort no_done", 32'(done), 32'd0);
      check("abort idle", 32'(busy), 32'd0);
    end
    do_op(4'd3, 4'd5, 15, "3x5");

    // Exhaustive operand sweep against a*b.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(4'(a), 4'(b), a * b, "sweep");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Guard against a hung handshake.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end

endmodule
